// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch and data
// requesters; one outstanding access at a time, fixed memory read latency.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    // Handshake: a requester holds req (and its address/data fields) stable until
    // the cycle its gnt is high; gnt is a one-cycle acceptance. rvalid is a
    // one-cycle pulse to the owner with no back-pressure.
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_mask,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [1:0]            fsm_state
);

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             last_d;
    logic             own_d;
    logic             op_we;

    // Grants are gated by rst so nothing is accepted while reset is held.
    assign i_gnt = rst && (state == ST_IDLE) && i_req && (!d_req || last_d);
    assign d_gnt = rst && (state == ST_IDLE) && d_req && (!i_req || !last_d);

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (i_gnt || d_gnt) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (cnt == '0) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            last_d    <= 1'b0;
            own_d     <= 1'b0;
            op_we     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
        end else begin
            // Memory command and response pulses are single-cycle by default.
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (d_gnt) begin
                        own_d     <= 1'b1;
                        op_we     <= d_we;
                        last_d    <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_addr  <= d_addr;
                        mem_we    <= d_we ? d_mask : '0;
                        mem_wdata <= d_wdata;
                    end else if (i_gnt) begin
                        own_d     <= 1'b0;
                        op_we     <= 1'b0;
                        last_d    <= 1'b0;
                        mem_en    <= 1'b1;
                        mem_addr  <= i_addr;
                    end
                end
                ST_ISSUE: cnt <= CNT_W'(MEM_LAT - 1);
                ST_WAIT: begin
                    // Count 0 marks the cycle the macro presents read data.
                    if (cnt == '0) begin
                        if (own_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= op_we ? '0 : mem_rdata;
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a
// cycle-level transaction model derived from the grant/latency rules.
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_mask = '0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;
  logic [1:0]  fsm_state;

  // Second instance with MEM_LAT=1 for the short-latency cycle count.
  logic        i_req1 = 1'b0, d_req1 = 1'b0, d_we1 = 1'b0;
  logic [31:0] i_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
  logic [3:0]  d_mask1 = '0;
  logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, mem_en1;
  logic [31:0] i_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_we1;
  logic [1:0]  fsm_state1;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_mask(d_mask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fsm_state(fsm_state)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req1), .i_addr(i_addr1), .i_gnt(i_gnt1), .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_mask(d_mask1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .fsm_state(fsm_state1)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- memory fixtures ----------------
  logic [31:0] fix_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic        pv [L];
  logic [31:0] pd [L];
  logic        fix1_v = 1'b0;
  logic [31:0] fix1_a = '0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                       input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] fix_read(input logic [31:0] a);
    return fix_mem.exists(a) ? fix_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Memory macro: data is presented only in the cycle exactly L after mem_en.
  always @(posedge clk) begin
    for (int k = L - 1; k > 0; k--) begin
      pv[k] <= pv[k-1];
      pd[k] <= pd[k-1];
    end
    pv[0] <= mem_en;
    pd[0] <= fix_read(mem_addr);
    if (mem_en && mem_we != 4'h0) fix_mem[mem_addr] = merge(fix_read(mem_addr), mem_wdata, mem_we);
  end
  assign mem_rdata = pv[L-1] ? pd[L-1] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    fix1_v <= mem_en1;
    fix1_a <= mem_addr1;
  end
  assign mem_rdata1 = fix1_v ? ~fix1_a : 32'h0BAD0BAD;

  // ---------------- driver / monitor ----------------
  logic        ref_last_d = 1'b0;
  int          obs_gnt, obs_en_k, obs_en_cnt, obs_rv_k, obs_rv_cnt;
  bit          obs_wrong, obs_nz;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_we;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one isolated transaction from an idle arbiter and records what it saw.
  task automatic run_single(input logic is_d, input logic we, input logic [3:0] mask,
                            input logic [31:0] addr, input logic [31:0] wdata);
    obs_gnt = -1; obs_en_k = -1; obs_en_cnt = 0; obs_rv_k = -1; obs_rv_cnt = 0;
    obs_wrong = 0; obs_nz = 0; obs_addr = '0; obs_wdata = '0; obs_rdata = '0; obs_we = '0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_mask = mask; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (is_d ? i_gnt : d_gnt) obs_wrong = 1;
      if (is_d ? d_gnt : i_gnt) begin
        obs_gnt = n;
        break;
      end
      next_cycle();
    end
    next_cycle();
    i_req = 1'b0; d_req = 1'b0;
    i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_mask = 4'($urandom); d_we = 1'($urandom);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_en) begin
        obs_en_cnt++;
        if (obs_en_k < 0) begin
          obs_en_k = k; obs_addr = mem_addr; obs_we = mem_we; obs_wdata = mem_wdata;
        end
      end else if (mem_we != 4'h0 || mem_addr != 32'h0 || mem_wdata != 32'h0) begin
        obs_nz = 1;
      end
      if (is_d ? d_rvalid : i_rvalid) begin
        obs_rv_cnt++;
        if (obs_rv_k < 0) begin
          obs_rv_k = k; obs_rdata = is_d ? d_rdata : i_rdata;
        end
      end
      if (is_d ? i_rvalid : d_rvalid) obs_wrong = 1;
      if (i_gnt || d_gnt) obs_wrong = 1;
      next_cycle();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h80; d_addr = 32'h40; d_we = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en});
    end
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== 68'h0) begin
      errors++; $display("FAIL reset_mem: got we=%h addr=%h wdata=%h expected 0", mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata: got i=%h d=%h expected 0", i_rdata, d_rdata);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({i_gnt, d_gnt} !== 2'b01) begin
      errors++; $display("FAIL reset_first_contention: got i_gnt,d_gnt=%b expected 01", {i_gnt, d_gnt});
    end
    next_cycle();
    i_req = 1'b0; d_req = 1'b0;
    repeat (10) next_cycle();
    ref_last_d = 1'b1;
  endtask

  task automatic test_single_fetch();
    fix_mem[32'h100] = 32'hDEADBEEF;
    ref_mem[32'h100] = 32'hDEADBEEF;
    run_single(1'b0, 1'b0, 4'h0, 32'h100, 32'h0);
    ref_last_d = 1'b0;
    checks++;
    if (obs_gnt !== 0) begin errors++; $display("FAIL fetch_gnt: got cycle %0d expected 0", obs_gnt); end
    checks++;
    if (obs_en_k !== 1 || obs_en_cnt !== 1) begin
      errors++; $display("FAIL fetch_issue: got first=%0d count=%0d expected 1/1", obs_en_k, obs_en_cnt);
    end
    checks++;
    if (obs_addr !== 32'h100 || obs_we !== 4'h0) begin
      errors++; $display("FAIL fetch_cmd: got addr=%h we=%h expected 00000100/0", obs_addr, obs_we);
    end
    checks++;
    if (obs_rv_k !== 2 + L || obs_rv_cnt !== 1) begin
      errors++; $display("FAIL fetch_rvalid: got at=%0d count=%0d expected %0d/1", obs_rv_k, obs_rv_cnt, 2 + L);
    end
    checks++;
    if (obs_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fetch_rdata: got %h expected deadbeef", obs_rdata);
    end
    checks++;
    if (obs_wrong || obs_nz) begin
      errors++; $display("FAIL fetch_side_effects: got wrong=%0d nonzero_idle=%0d expected 0/0", obs_wrong, obs_nz);
    end
  endtask

  task automatic test_data_write();
    ref_mem[32'h2004] = merge(ref_read(32'h2004), 32'h12345678, 4'h3);
    run_single(1'b1, 1'b1, 4'h3, 32'h2004, 32'h12345678);
    ref_last_d = 1'b1;
    checks++;
    if (obs_gnt !== 0 || obs_en_k !== 1 || obs_en_cnt !== 1) begin
      errors++; $display("FAIL write_timing: got gnt=%0d en=%0d/%0d expected 0, 1/1", obs_gnt, obs_en_k, obs_en_cnt);
    end
    checks++;
    if (obs_we !== 4'h3 || obs_addr !== 32'h2004 || obs_wdata !== 32'h12345678) begin
      errors++; $display("FAIL write_cmd: got we=%h addr=%h wdata=%h expected 3/2004/12345678", obs_we, obs_addr, obs_wdata);
    end
    checks++;
    if (obs_rv_k !== 2 + L || obs_rv_cnt !== 1 || obs_rdata !== 32'h0) begin
      errors++; $display("FAIL write_ack: got at=%0d count=%0d rdata=%h expected %0d/1/0", obs_rv_k, obs_rv_cnt, obs_rdata, 2 + L);
    end
    checks++;
    if (obs_wrong || obs_nz) begin
      errors++; $display("FAIL write_side_effects: got wrong=%0d nonzero_idle=%0d expected 0/0", obs_wrong, obs_nz);
    end
    checks++;
    if (i_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL fetch_rdata_hold: got %h expected deadbeef", i_rdata);
    end
  endtask

  task automatic test_data_read();
    logic [31:0] exp_d, wd;
    exp_d = ref_read(32'h2004);
    wd = $urandom;
    run_single(1'b1, 1'b0, 4'hF, 32'h2004, wd);
    ref_last_d = 1'b1;
    checks++;
    if (obs_we !== 4'h0 || obs_addr !== 32'h2004 || obs_wdata !== wd) begin
      errors++; $display("FAIL read_cmd: got we=%h addr=%h wdata=%h expected 0/2004/%h", obs_we, obs_addr, obs_wdata, wd);
    end
    checks++;
    if (obs_rv_k !== 2 + L || obs_rdata !== exp_d) begin
      errors++; $display("FAIL read_data: got at=%0d rdata=%h expected %0d/%h", obs_rv_k, obs_rdata, 2 + L, exp_d);
    end
  endtask

  task automatic test_reset_mid();
    int  g = -1;
    bit  late = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (d_gnt) begin g = n; break; end
      next_cycle();
    end
    checks++;
    if (g !== 0) begin errors++; $display("FAIL midreset_gnt: got cycle %0d expected 0", g); end
    next_cycle();
    d_req = 1'b0;
    next_cycle();
    rst = 1'b0;
    #1;
    checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en} !== 5'b0 || {mem_we, mem_addr, mem_wdata} !== 68'h0) begin
      errors++; $display("FAIL midreset_outputs: got ctrl=%b mem=%h expected 0", {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en}, {mem_we, mem_addr, mem_wdata});
    end
    checks++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      errors++; $display("FAIL midreset_rdata: got i=%h d=%h expected 0", i_rdata, d_rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (i_rvalid || d_rvalid || mem_en) late = 1;
      next_cycle();
    end
    checks++;
    if (late) begin errors++; $display("FAIL midreset_dropped: got activity after release expected none"); end
    ref_last_d = 1'b0;
  endtask

  task automatic test_contention();
    int          exp_next = 0;
    logic        nxt_d;
    logic        eig, edg;
    logic        e_irv, e_drv, own;
    logic [31:0] e_data;
    int          due_q[$];
    logic        own_q[$];
    logic [31:0] exp_q[$];
    bit          chg_i, chg_d;
    nxt_d = !ref_last_d;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h3000 + 4 * 32'($urandom_range(0, 15));
    d_addr = 32'h3000 + 4 * 32'($urandom_range(0, 15));
    for (int c = 0; c < 50; c++) begin
      if (c == 40) begin i_req = 1'b0; d_req = 1'b0; end
      @(negedge clk);
      eig = (c == exp_next) && (c < 40) && !nxt_d;
      edg = (c == exp_next) && (c < 40) && nxt_d;
      checks++;
      if ({i_gnt, d_gnt} !== {eig, edg}) begin
        errors++; $display("FAIL contention_gnt c=%0d: got i,d=%b expected %b", c, {i_gnt, d_gnt}, {eig, edg});
      end
      chg_i = 0; chg_d = 0;
      if (eig || edg) begin
        due_q.push_back(c + 2 + L);
        own_q.push_back(edg);
        exp_q.push_back(ref_read(edg ? d_addr : i_addr));
        ref_last_d = edg;
        nxt_d = !edg;
        exp_next = c + 3 + L;
        chg_i = eig; chg_d = edg;
      end
      e_irv = 0; e_drv = 0; e_data = '0;
      if (due_q.size() > 0 && due_q[0] == c) begin
        void'(due_q.pop_front());
        own = own_q.pop_front();
        e_data = exp_q.pop_front();
        e_irv = !own; e_drv = own;
      end
      checks++;
      if ({i_rvalid, d_rvalid} !== {e_irv, e_drv} ||
          (e_irv && i_rdata !== e_data) || (e_drv && d_rdata !== e_data)) begin
        errors++; $display("FAIL contention_resp c=%0d: got rv=%b i=%h d=%h expected rv=%b data=%h",
                           c, {i_rvalid, d_rvalid}, i_rdata, d_rdata, {e_irv, e_drv}, e_data);
      end
      next_cycle();
      if (chg_i) i_addr = 32'h3000 + 4 * 32'($urandom_range(0, 15));
      if (chg_d) d_addr = 32'h3000 + 4 * 32'($urandom_range(0, 15));
    end
    checks++;
    if (due_q.size() != 0) begin
      errors++; $display("FAIL contention_drain: got %0d responses missing expected 0", due_q.size());
    end
  endtask

  task automatic test_wait_behaviour();
    int          g = -1, kirv = -1, kdg = -1, kdrv = -1;
    logic [31:0] rd_i = '0, rd_d = '0, exp_i, exp_d;
    exp_i = ref_read(32'h180);
    exp_d = ref_read(32'h1C0);
    i_req = 1'b1; i_addr = 32'h180;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (i_gnt) begin g = n; break; end
      next_cycle();
    end
    next_cycle();
    i_req = 1'b0;
    next_cycle();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1C0;
    for (int k = 2; k <= 14; k++) begin
      @(negedge clk);
      if (i_rvalid && kirv < 0) begin kirv = k; rd_i = i_rdata; end
      if (d_gnt && kdg < 0) kdg = k;
      if (d_rvalid && kdrv < 0) begin kdrv = k; rd_d = d_rdata; end
      next_cycle();
      if (kdg >= 0) d_req = 1'b0;
    end
    ref_last_d = 1'b1;
    checks++;
    if (g !== 0 || kirv !== 2 + L || rd_i !== exp_i) begin
      errors++; $display("FAIL wait_fetch: got gnt=%0d rvalid_at=%0d rdata=%h expected 0/%0d/%h", g, kirv, rd_i, 2 + L, exp_i);
    end
    checks++;
    if (kdg !== 3 + L) begin
      errors++; $display("FAIL wait_dgnt: got cycle %0d expected %0d", kdg, 3 + L);
    end
    checks++;
    if (kdrv !== 5 + 2 * L || rd_d !== exp_d) begin
      errors++; $display("FAIL wait_dresp: got at=%0d rdata=%h expected %0d/%h", kdrv, rd_d, 5 + 2 * L, exp_d);
    end
  endtask

  task automatic test_lat1();
    logic [31:0] a1_q[$];
    logic [31:0] e_data;
    logic        eg, ee, er;
    i_req1 = 1'b1;
    i_addr1 = $urandom;
    for (int c = 0; c < 20; c++) begin
      if (c == 16) i_req1 = 1'b0;
      @(negedge clk);
      eg = (c < 16) && (c % 4 == 0);
      ee = (c < 17) && (c % 4 == 1);
      er = (c < 16) && (c % 4 == 3);
      checks++;
      if ({i_gnt1, d_gnt1, mem_en1, i_rvalid1, d_rvalid1} !== {eg, 1'b0, ee, er, 1'b0}) begin
        errors++; $display("FAIL lat1_timing c=%0d: got %b expected %b", c,
                           {i_gnt1, d_gnt1, mem_en1, i_rvalid1, d_rvalid1}, {eg, 1'b0, ee, er, 1'b0});
      end
      if (eg) a1_q.push_back(i_addr1);
      if (er && a1_q.size() > 0) begin
        e_data = ~a1_q.pop_front();
        checks++;
        if (i_rdata1 !== e_data) begin
          errors++; $display("FAIL lat1_rdata c=%0d: got %h expected %h", c, i_rdata1, e_data);
        end
      end
      next_cycle();
      if (eg) i_addr1 = $urandom;
    end
  endtask

  task automatic test_random();
    int          next_free = 0, iss_cyc = -1;
    bit          ip = 0, dp = 0, ih_ok = 0, dh_ok = 0;
    logic [31:0] ia = '0, da = '0, dw = '0, iss_addr = '0, iss_wdata = '0, ih = '0, dh = '0, e_data;
    logic [3:0]  dm = '0, iss_we = '0;
    logic        dwe = 1'b0, last_d, eig, edg, e_irv, e_drv, own;
    int          due_q[$];
    logic        own_q[$];
    logic [31:0] exp_q[$];
    last_d = ref_last_d;
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 380) begin
        if (!ip && $urandom_range(0, 2) == 0) begin
          ip = 1; ia = 32'h3000 + 4 * 32'($urandom_range(0, 15));
        end else if (ip && $urandom_range(0, 7) == 0) begin
          ip = 0;
        end
        if (!dp && $urandom_range(0, 2) == 0) begin
          dp = 1; da = 32'h3000 + 4 * 32'($urandom_range(0, 15));
          dw = $urandom; dm = 4'($urandom_range(0, 15)); dwe = 1'($urandom_range(0, 1));
        end else if (dp && $urandom_range(0, 7) == 0) begin
          dp = 0;
        end
      end else begin
        ip = 0; dp = 0;
      end
      i_req = ip; i_addr = ia;
      d_req = dp; d_addr = da; d_wdata = dw; d_mask = dm; d_we = dwe;
      @(negedge clk);
      eig = 0; edg = 0;
      if (cyc >= next_free) begin
        if (ip && dp) begin eig = last_d; edg = !last_d; end
        else begin eig = ip; edg = dp; end
      end
      checks++;
      if ({i_gnt, d_gnt} !== {eig, edg}) begin
        errors++; $display("FAIL random_gnt c=%0d: got i,d=%b expected %b", cyc, {i_gnt, d_gnt}, {eig, edg});
      end
      if (eig || edg) begin
        due_q.push_back(cyc + 2 + L);
        own_q.push_back(edg);
        exp_q.push_back((edg && dwe) ? 32'h0 : ref_read(edg ? da : ia));
        if (edg && dwe) ref_mem[da] = merge(ref_read(da), dw, dm);
        iss_cyc = cyc + 1;
        iss_addr = edg ? da : ia;
        iss_we = (edg && dwe) ? dm : 4'h0;
        iss_wdata = edg ? dw : 32'h0;
        next_free = cyc + 3 + L;
        last_d = edg;
        if (edg) dp = 0; else ip = 0;
      end
      checks++;
      if (cyc == iss_cyc) begin
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, iss_we, iss_addr, iss_wdata}) begin
          errors++; $display("FAIL random_issue c=%0d: got en=%b we=%h addr=%h wdata=%h expected 1/%h/%h/%h",
                             cyc, mem_en, mem_we, mem_addr, mem_wdata, iss_we, iss_addr, iss_wdata);
        end
      end else if ({mem_en, mem_we, mem_addr, mem_wdata} !== 69'h0) begin
        errors++; $display("FAIL random_mem_idle c=%0d: got en=%b we=%h addr=%h wdata=%h expected 0",
                           cyc, mem_en, mem_we, mem_addr, mem_wdata);
      end
      e_irv = 0; e_drv = 0; e_data = '0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        own = own_q.pop_front();
        e_data = exp_q.pop_front();
        e_irv = !own; e_drv = own;
        if (own) begin dh = e_data; dh_ok = 1; end
        else begin ih = e_data; ih_ok = 1; end
      end
      checks++;
      if ({i_rvalid, d_rvalid} !== {e_irv, e_drv}) begin
        errors++; $display("FAIL random_rvalid c=%0d: got i,d=%b expected %b", cyc, {i_rvalid, d_rvalid}, {e_irv, e_drv});
      end
      if (ih_ok) begin
        checks++;
        if (i_rdata !== ih) begin errors++; $display("FAIL random_i_rdata c=%0d: got %h expected %h", cyc, i_rdata, ih); end
      end
      if (dh_ok) begin
        checks++;
        if (d_rdata !== dh) begin errors++; $display("FAIL random_d_rdata c=%0d: got %h expected %h", cyc, d_rdata, dh); end
      end
      next_cycle();
    end
    checks++;
    if (due_q.size() != 0) begin
      errors++; $display("FAIL random_drain: got %0d responses missing expected 0", due_q.size());
    end
    ref_last_d = last_d;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_fetch();
    test_data_write();
    test_data_read();
    test_reset_mid();
    test_contention();
    test_wait_behaviour();
    test_lat1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
